// File: rtl/pma_tx_serializer_v2.sv
`default_nettype none
// ============================================================================
// Module      : pma_tx_serializer_v2
// Description : PMA transmit serializer. Accepts parallel symbols over a
//               valid/ready handshake into a one-word holding register and
//               shifts them onto a differential pair one bit per clock, with
//               zero gap between back-to-back words. Supports a selectable bit
//               order, lane polarity inversion, a configurable idle level and
//               an underrun pulse.
// Revision    : 2.0 - initial release of the parametrised serializer
// ============================================================================
module pma_tx_serializer_v2 #(
    parameter int DATA_WIDTH = 10,    // symbol width, 2..64
    parameter bit MSB_FIRST  = 1'b0,  // 1: bit DATA_WIDTH-1 leaves first
    parameter bit IDLE_BIT   = 1'b0   // raw line level with no word in flight
) (
    input  logic                  Bit_Rate_Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    input  logic                  TX_En,
    input  logic                  Polarity_Inv,
    output logic                  TX_Out_P,
    output logic                  TX_Out_N,
    output logic                  Word_Start,
    output logic                  Underrun
);

    // Counter tracks the index of the bit currently on the line.
    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_TRANSMIT = 1'b1
    } state_t;

    state_t                state_q,      state_d;
    logic [DATA_WIDTH-1:0] hold_q,       hold_d;
    logic                  hold_full_q,  hold_full_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  tx_p_q,       tx_p_d;
    logic                  word_start_q, word_start_d;
    logic                  underrun_q,   underrun_d;

    logic                  word_done;    // last bit of the current word is on the line
    logic                  load;         // held word moves to the shift register this edge
    logic                  accept;       // new word enters the holding register this edge
    logic [DATA_WIDTH-1:0] advanced;     // shift register stepped by one bit
    logic                  next_bit;     // bit the line shows after this edge

    assign word_done  = (state_q == ST_TRANSMIT) && (cnt_q == CNT_LAST);
    assign load       = hold_full_q && TX_En && ((state_q == ST_IDLE) || word_done);

    // The holding register may be refilled on the very edge it empties.
    assign Data_Ready = !hold_full_q || load;
    assign accept     = Data_Valid && Data_Ready;

    // The shift register rotates so that the outgoing bit always sits at the
    // transmit end; the bits wrapped round are never shown again.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign advanced = {shift_q[DATA_WIDTH-2:0], shift_q[DATA_WIDTH-1]};
            assign next_bit = shift_d[DATA_WIDTH-1];
        end else begin : g_lsb_first
            assign advanced = {shift_q[0], shift_q[DATA_WIDTH-1:1]};
            assign next_bit = shift_d[0];
        end
    endgenerate

    // Next-state decode for the holding register, word sequencer and flags
    always_comb begin
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_start_d = 1'b0;
        underrun_d   = 1'b0;

        if (accept) begin
            hold_d      = Data_in;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end

        if (load) begin
            // Covers both the start from idle and the seamless follow-on word.
            state_d      = ST_TRANSMIT;
            shift_d      = hold_q;
            cnt_d        = '0;
            word_start_d = 1'b1;
        end else if (state_q == ST_TRANSMIT) begin
            if (word_done) begin
                // Nothing to follow: flag a starved link only while enabled.
                state_d    = ST_IDLE;
                cnt_d      = '0;
                underrun_d = TX_En && !hold_full_q;
            end else begin
                shift_d = advanced;
                cnt_d   = cnt_q + CNT_ONE;
            end
        end
    end

    // Line level for the next bit period, with inversion applied last.
    assign tx_p_d = ((state_d == ST_TRANSMIT) ? next_bit : IDLE_BIT) ^ Polarity_Inv;

    // State and output registers; reset aborts any word and drops the held one
    always_ff @(posedge Bit_Rate_Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            tx_p_q       <= IDLE_BIT;
            word_start_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            tx_p_q       <= tx_p_d;
            word_start_q <= word_start_d;
            underrun_q   <= underrun_d;
        end
    end

    assign TX_Out_P   = tx_p_q;
    assign TX_Out_N   = ~tx_p_q;
    assign Word_Start = word_start_q;
    assign Underrun   = underrun_q;

endmodule
`default_nettype wire

// File: doc/pma_tx_serializer_v2.md
Name: pma_tx_serializer_v2

Overview:
Parametrised next-generation PMA transmit serializer. Accepts parallel symbols from the PCS/MAC side over a valid/ready handshake and buffers one word in a holding register. It shifts words out one bit per Bit_Rate_Clk with no gap between back-to-back words, and drives a differential pair with configurable bit order, lane polarity inversion, idle level and underrun signalling.

Parameters:
DATA_WIDTH, 10, symbol width in bits (legal range 2..64).
MSB_FIRST, 0, 0 = bit 0 transmitted first; 1 = bit DATA_WIDTH-1 transmitted first.
IDLE_BIT, 0, raw line level driven while no word is in flight (before polarity inversion).

Ports:
Bit_Rate_Clk  in  1  serial bit clock; all state changes on the rising edge.
Rst  in  1  asynchronous, active-high reset.
Data_in  in  DATA_WIDTH  parallel symbol.
Data_Valid  in  1  Data_in is valid.
Data_Ready  out  1  block can accept Data_in on this edge.
TX_En  in  1  enable for starting new words.
Polarity_Inv  in  1  invert the line output.
TX_Out_P  out  1  serial output, registered.
TX_Out_N  out  1  always ~TX_Out_P.
Word_Start  out  1  high during the bit period in which the first bit of a word is on the line.
Underrun  out  1  one-cycle pulse, defined under Underrun.

Behaviour:
- Reset (async, Rst=1): state IDLE, holding register empty, shift register 0, bit counter 0, Word_Start 0, Underrun 0, TX_Out_P = IDLE_BIT ^ 0 = IDLE_BIT. TX_Out_N is the complement. Asserting Rst mid-word aborts the word immediately and drops the held word.
- Handshake: a word is accepted on an edge where Data_Valid && Data_Ready.
  - Data_Ready = !hold_full || hold_transfer, where hold_transfer means the held word moves to the shift register on this edge.
  - Accept and transfer on the same edge is legal: the new word refills the holding register.
  - Data_Valid while Data_Ready=0 is ignored; the source must hold its data.
- FSM states IDLE and TRANSMIT.
  - IDLE -> TRANSMIT when hold_full && TX_En. Shift register loads the held word, counter = 0, hold empties (unless refilled on the same edge).
  - TRANSMIT, counter < DATA_WIDTH-1: shift one bit and increment counter.
  - TRANSMIT, counter == DATA_WIDTH-1, hold_full && TX_En: load the next word seamlessly, counter = 0, stay in TRANSMIT.
  - TRANSMIT, counter == DATA_WIDTH-1, otherwise: go to IDLE.
- Latency: a word accepted at edge e0 into an empty, IDLE block loads at e1. TX_Out_P shows bit index 0 (per MSB_FIRST) after e1 and bit i after e1+i. A following word shows its first bit after e1+DATA_WIDTH with zero idle gap.
- Output register: TX_Out_P <= (TRANSMIT-next ? next_bit : IDLE_BIT) ^ Polarity_Inv. Polarity_Inv is sampled every edge, so a change takes effect on the next bit period.
- Word_Start: registered, high for exactly the bit period showing a word's first bit.
- TX_En: deasserting mid-word never truncates; the current word completes, then the FSM goes to IDLE and the held word is retained. TX_En does not gate Data_Ready.
- Underrun: pulses for one cycle, coincident with the first idle bit period, when a word finishes with TX_En=1 and the holding register empty. There is no pulse when TX_En=0.
- Counter width: $clog2(DATA_WIDTH); the counter never exceeds DATA_WIDTH-1.

Test Plan:
1. Reset: assert Rst mid-word with IDLE_BIT=0 -> TX_Out_P=0, TX_Out_N=1, Data_Ready=1, Word_Start=0 asynchronously. After release the line stays idle until a new word arrives.
2. Single word, LSB first, DATA_WIDTH=10, TX_En=1: Data_in=10'h305 accepted at e0 -> after e1..e10, TX_Out_P = 1,0,1,0,0,0,0,0,1,1. Word_Start high only after e1. After e11, line=IDLE_BIT and Underrun pulses one cycle.
3. Back-to-back: send 10'h3FF then 10'h000 with Data_Valid held high -> 10 ones then 10 zeros with no gap. Data_Ready drops after the first accept. The second accept coincides with the hold_transfer edge. No Underrun between the words.
4. MSB_FIRST=1 instance: Data_in=10'h200 -> first bit 1, then nine 0s.
5. Polarity: toggle Polarity_Inv=1 at bit 4 of a 10'h0F0 word -> bits 5..9 inverted on TX_Out_P. Idle level becomes ~IDLE_BIT. TX_Out_N is always the complement.
6. TX_En drop: TX_En=0 at bit 3 with the next word held -> current word completes, FSM goes to IDLE, no Underrun, Data_Ready=0. Re-assert TX_En -> the held word starts on the next edge with Word_Start=1.
